// File: rtl/hdlc_pkg.sv
// Shared constants and state encoding for the HDLC transmit path.
package hdlc_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] FLAG_PATTERN  = 8'h7E;
    // Sent LSB first: a single 0 followed by seven 1s.
    localparam logic [BYTE_W-1:0] ABORT_PATTERN = 8'hFE;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_START_FLAG = 3'd1;
    localparam logic [2:0] ST_DATA       = 3'd2;
    localparam logic [2:0] ST_END_FLAG   = 3'd3;
    localparam logic [2:0] ST_ABORT      = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        START_FLAG = ST_START_FLAG,
        DATA       = ST_DATA,
        END_FLAG   = ST_END_FLAG,
        ABORT      = ST_ABORT
    } tx_state_t;

endpackage

// File: rtl/hdlc_zero_inserter.sv
// Counts consecutive payload 1s and asks the shifter to hold for one cycle
// while a stuffed 0 goes out. Only active while payload is on the line.
module hdlc_zero_inserter #(
    parameter int ONES_RUN = 5
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Enable,
    input  logic DataBit,
    output logic Hold,
    output logic HoldNext
);

    localparam int CNT_W = $clog2(ONES_RUN + 1);

    logic [CNT_W-1:0] onesCntReg;
    logic             emitted;

    assign Hold     = Enable && (onesCntReg == CNT_W'(ONES_RUN));
    assign emitted  = DataBit && !Hold;
    // Tells the framer that the bit going out now will force a stuffed 0 next.
    assign HoldNext = Enable && emitted && (onesCntReg == CNT_W'(ONES_RUN - 1));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            onesCntReg <= '0;
        end else if (!Enable || !emitted) begin
            onesCntReg <= '0;
        end else begin
            onesCntReg <= onesCntReg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: pulls bytes from the Tx buffer, wraps them in flags,
// stuffs zeros, and handles abort/underrun; one line bit per Clk.
module hdlc_tx_framer #(
    parameter int MAX_FRAME_BYTES = 128,
    parameter int ONES_RUN        = 5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Start,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_DataAvail,
    input  logic       Tx_LastByte,
    input  logic       Tx_AbortFrame,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Done,
    output logic       Tx_Busy
);

    import hdlc_pkg::*;

    localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);

    tx_state_t         stateReg;
    logic [2:0]        bitCntReg;
    logic [BYTE_W-1:0] shiftReg;
    logic              lastReg;
    logic              endPendReg;
    logic              doneReg;
    logic              abortedReg;
    logic [CNT_W-1:0]  byteCntReg;

    logic hold;
    logic holdNext;
    logic inData;
    logic byteEnd;
    logic canPop;
    logic startOk;
    logic popData;
    logic txBit;

    hdlc_zero_inserter #(
        .ONES_RUN (ONES_RUN)
    ) zeroInserter (
        .Clk      (Clk),
        .Rst      (Rst),
        .Enable   (inData),
        .DataBit  (shiftReg[0]),
        .Hold     (hold),
        .HoldNext (holdNext)
    );

    assign inData  = (stateReg == DATA);
    assign byteEnd = inData && !hold && (bitCntReg == 3'd7);
    assign canPop  = Tx_DataAvail && (byteCntReg < CNT_W'(MAX_FRAME_BYTES));
    assign startOk = Rst && (stateReg == IDLE) && Tx_Start && Tx_DataAvail;
    // An abort request wins over fetching the next byte.
    assign popData = byteEnd && !lastReg && canPop && !Tx_AbortFrame;

    always_comb begin
        txBit = 1'b1;
        case (stateReg)
            START_FLAG, END_FLAG: txBit = FLAG_PATTERN[bitCntReg];
            DATA:                 txBit = hold ? 1'b0 : shiftReg[0];
            ABORT:                txBit = ABORT_PATTERN[bitCntReg];
            default:              txBit = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stateReg   <= IDLE;
            bitCntReg  <= '0;
            shiftReg   <= '0;
            lastReg    <= 1'b0;
            endPendReg <= 1'b0;
            doneReg    <= 1'b0;
            abortedReg <= 1'b0;
            byteCntReg <= '0;
        end else begin
            doneReg    <= 1'b0;
            abortedReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (startOk) begin
                        shiftReg   <= Tx_Data;
                        lastReg    <= Tx_LastByte;
                        byteCntReg <= CNT_W'(1);
                        bitCntReg  <= '0;
                        endPendReg <= 1'b0;
                        stateReg   <= START_FLAG;
                    end
                end
                START_FLAG: begin
                    if (Tx_AbortFrame) begin
                        stateReg  <= ABORT;
                        bitCntReg <= '0;
                    end else begin
                        bitCntReg <= bitCntReg + 3'd1;
                        if (bitCntReg == 3'd7) begin
                            stateReg <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (Tx_AbortFrame) begin
                        stateReg  <= ABORT;
                        bitCntReg <= '0;
                    end else if (hold) begin
                        // Stuffed 0 on the line; the last byte may be waiting on it.
                        if (endPendReg) begin
                            stateReg   <= END_FLAG;
                            bitCntReg  <= '0;
                            endPendReg <= 1'b0;
                        end
                    end else if (bitCntReg == 3'd7) begin
                        if (lastReg) begin
                            if (holdNext) begin
                                endPendReg <= 1'b1;
                            end else begin
                                stateReg  <= END_FLAG;
                                bitCntReg <= '0;
                            end
                        end else if (canPop) begin
                            shiftReg   <= Tx_Data;
                            lastReg    <= Tx_LastByte;
                            byteCntReg <= byteCntReg + CNT_W'(1);
                            bitCntReg  <= '0;
                        end else begin
                            // Buffer ran dry or the frame is too long.
                            stateReg  <= ABORT;
                            bitCntReg <= '0;
                        end
                    end else begin
                        shiftReg  <= shiftReg >> 1;
                        bitCntReg <= bitCntReg + 3'd1;
                    end
                end
                END_FLAG: begin
                    bitCntReg <= bitCntReg + 3'd1;
                    if (bitCntReg == 3'd7) begin
                        stateReg <= IDLE;
                        doneReg  <= 1'b1;
                    end
                end
                ABORT: begin
                    bitCntReg <= bitCntReg + 3'd1;
                    if (bitCntReg == 3'd7) begin
                        stateReg   <= IDLE;
                        abortedReg <= 1'b1;
                    end
                end
                default: begin
                    stateReg  <= IDLE;
                    bitCntReg <= '0;
                end
            endcase
        end
    end

    assign Tx              = txBit;
    assign Tx_RdBuff       = startOk || popData;
    assign Tx_ValidFrame   = inData;
    assign Tx_Busy         = (stateReg != IDLE);
    assign Tx_Done         = doneReg;
    assign Tx_AbortedTrans = abortedReg;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: per-cycle expected line/status vectors
// are queued with each frame and compared as the DUT shifts them out.
module tb_hdlc_tx_framer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Tx_Start = 1'b0;
    logic [7:0] Tx_Data = 8'h00;
    logic       Tx_DataAvail = 1'b0;
    logic       Tx_LastByte = 1'b0;
    logic       Tx_AbortFrame = 1'b0;
    logic       Tx_RdBuff;
    logic       Tx;
    logic       Tx_ValidFrame;
    logic       Tx_AbortedTrans;
    logic       Tx_Done;
    logic       Tx_Busy;

    always #5 Clk = ~Clk;

    hdlc_tx_framer dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Tx_Start        (Tx_Start),
        .Tx_Data         (Tx_Data),
        .Tx_DataAvail    (Tx_DataAvail),
        .Tx_LastByte     (Tx_LastByte),
        .Tx_AbortFrame   (Tx_AbortFrame),
        .Tx_RdBuff       (Tx_RdBuff),
        .Tx              (Tx),
        .Tx_ValidFrame   (Tx_ValidFrame),
        .Tx_AbortedTrans (Tx_AbortedTrans),
        .Tx_Done         (Tx_Done),
        .Tx_Busy         (Tx_Busy)
    );

    // Vector layout: {Tx, Tx_ValidFrame, Tx_Busy, Tx_Done, Tx_AbortedTrans, Tx_RdBuff}
    localparam logic [5:0] V_IDLE    = 6'b100000;
    localparam logic [5:0] V_DONE    = 6'b100100;
    localparam logic [5:0] V_ABORTED = 6'b100010;
    localparam logic [5:0] V_STUFF   = 6'b011000;

    logic [5:0] obsV;
    assign obsV = {Tx, Tx_ValidFrame, Tx_Busy, Tx_Done, Tx_AbortedTrans, Tx_RdBuff};

    logic [5:0] expQ[$];
    logic [8:0] srcQ[$];
    logic [7:0] byteQ[$];
    int  nAsserts = 0;
    int  nFails   = 0;
    int  cyc      = 0;
    int  startAt  = -1;
    int  startAt2 = -1;
    int  abortAt  = -1;
    bit  rdSeen   = 1'b0;

    task automatic check(input string tag, input logic [5:0] expV);
        nAsserts++;
        assert (obsV === expV) else begin
            nFails++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obsV, expV);
        end
    endtask

    task automatic pushRow(input logic [5:0] v);
        expQ.push_back(v);
    endtask

    task automatic pushPattern(input logic [7:0] pat);
        logic [7:0] p;
        p = pat;
        for (int i = 0; i < 8; i++) pushRow({p[i], 5'b01000});
    endtask

    // Stuffed payload followed by either a closing flag or an abort pattern.
    task automatic pushPayload(input logic [7:0] bytes[$], input bit endFlag);
        int   ones;
        logic b;
        logic rd;
        ones = 0;
        for (int k = 0; k < bytes.size(); k++) begin
            for (int i = 0; i < 8; i++) begin
                b  = bytes[k][i];
                rd = (i == 7) && (k < bytes.size() - 1);
                pushRow({b, 1'b1, 1'b1, 1'b0, 1'b0, rd});
                ones = b ? ones + 1 : 0;
                if (ones == 5) begin
                    if (endFlag || !(k == bytes.size() - 1 && i == 7)) pushRow(V_STUFF);
                    ones = 0;
                end
            end
        end
        if (endFlag) begin
            pushPattern(8'h7E);
            pushRow(V_DONE);
        end else begin
            pushPattern(8'hFE);
            pushRow(V_ABORTED);
        end
        pushRow(V_IDLE);
    endtask

    task automatic oneCycle(input string tag);
        logic [8:0] dummy;
        @(posedge Clk);
        if (rdSeen && srcQ.size() > 0) dummy = srcQ.pop_front();
        #1;
        Tx_Start      = (cyc == startAt) || (cyc == startAt2);
        Tx_AbortFrame = (cyc == abortAt);
        Tx_DataAvail  = (srcQ.size() > 0);
        {Tx_LastByte, Tx_Data} = (srcQ.size() > 0) ? srcQ[0] : 9'h000;
        @(negedge Clk);
        rdSeen = Tx_RdBuff;
        if (expQ.size() > 0) check(tag, expQ.pop_front());
        else check(tag, V_IDLE);
        cyc++;
    endtask

    task automatic runFrame(input string tag);
        int n;
        n   = expQ.size();
        cyc = 0;
        while (expQ.size() > 0) oneCycle(tag);
        $display("frame %s: %0d cycles checked", tag, n);
        startAt = -1; startAt2 = -1; abortAt = -1;
        srcQ.delete();
        Tx_Start = 1'b0; Tx_AbortFrame = 1'b0; Tx_DataAvail = 1'b0; Tx_LastByte = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        check("reset_idle", V_IDLE);
        Rst = 1'b1;
        @(negedge Clk);

        // Single last byte 0x00
        srcQ.push_back({1'b1, 8'h00});
        byteQ.delete(); byteQ.push_back(8'h00);
        pushRow(6'b100001); pushPattern(8'h7E); pushPayload(byteQ, 1'b1);
        startAt = 0; runFrame("single_00");

        // Single last byte 0xFF: one stuffed zero mid-byte
        srcQ.push_back({1'b1, 8'hFF});
        byteQ.delete(); byteQ.push_back(8'hFF);
        pushRow(6'b100001); pushPattern(8'h7E); pushPayload(byteQ, 1'b1);
        startAt = 0; runFrame("single_FF");

        // 0x1F then 0xF8: stuffing inside byte 1 and after the final bit 7
        srcQ.push_back({1'b0, 8'h1F}); srcQ.push_back({1'b1, 8'hF8});
        byteQ.delete(); byteQ.push_back(8'h1F); byteQ.push_back(8'hF8);
        pushRow(6'b100001); pushPattern(8'h7E); pushPayload(byteQ, 1'b1);
        startAt = 0; runFrame("two_bytes");

        // Abort requested on the third payload bit of 0x55
        srcQ.push_back({1'b0, 8'h55}); srcQ.push_back({1'b1, 8'h33});
        pushRow(6'b100001); pushPattern(8'h7E);
        pushRow(6'b111000); pushRow(6'b011000); pushRow(6'b111000);
        pushPattern(8'hFE); pushRow(V_ABORTED); pushRow(V_IDLE);
        startAt = 0; abortAt = 11; runFrame("abort_req");

        // Underrun: only one non-last byte is ever available
        srcQ.push_back({1'b0, 8'hA5});
        byteQ.delete(); byteQ.push_back(8'hA5);
        pushRow(6'b100001); pushPattern(8'h7E); pushPayload(byteQ, 1'b0);
        startAt = 0; runFrame("underrun");

        // 129-byte frame: pop 129 is refused and the frame aborts
        byteQ.delete();
        for (int k = 0; k < 129; k++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            srcQ.push_back({(k == 128), d});
            if (k < 128) byteQ.push_back(d);
        end
        pushRow(6'b100001); pushPattern(8'h7E); pushPayload(byteQ, 1'b0);
        startAt = 0; runFrame("too_long");

        // Asynchronous reset in the middle of the payload
        srcQ.push_back({1'b1, 8'h3C});
        byteQ.delete(); byteQ.push_back(8'h3C);
        pushRow(6'b100001); pushPattern(8'h7E); pushPayload(byteQ, 1'b1);
        startAt = 0; cyc = 0;
        repeat (12) oneCycle("reset_mid");
        #2 Rst = 1'b0;
        #1 check("reset_async", V_IDLE);
        expQ.delete(); srcQ.delete(); rdSeen = 1'b0; startAt = -1;
        Tx_Start = 1'b0; Tx_DataAvail = 1'b0; Tx_LastByte = 1'b0; Tx_AbortFrame = 1'b0;
        @(negedge Clk);
        check("reset_hold", V_IDLE);
        Rst = 1'b1;
        $display("frame reset_mid: reset applied after 12 cycles");

        // Clean frame after reset; a second Tx_Start during the flag is ignored
        srcQ.push_back({1'b1, 8'h81}); srcQ.push_back({1'b1, 8'hAA});
        byteQ.delete(); byteQ.push_back(8'h81);
        pushRow(6'b100001); pushPattern(8'h7E); pushPayload(byteQ, 1'b1);
        startAt = 0; startAt2 = 4; runFrame("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
